riptide_io_mod: RTL and testbench

- I/O interface block for the 8X-RIPTIDE CPU (8X300-style).
- Decodes the CPU's active-low IV bus and its select/write commands into two independent peripheral banks: left (LB) and right (RB).
- Each bank has an 8-bit address register and an 8-bit data-out register.
- Returns the selected bank's read data to the CPU over the active-low IV input.

---
 rtl/riptide_io_mod.sv | 85 ++++++++
 tb/tb_riptide_io_mod.sv | 123 ++++++++++++
 2 files changed

// File: rtl/riptide_io_mod.sv
// riptide_io_mod
//   I/O interface block for the 8X-RIPTIDE CPU (8X300-style IV bus).
//   It decodes the CPU's active-low IV bus and its select/write commands
//   into two independent peripheral banks, left (LB) and right (RB). Each
//   bank has an 8-bit address register and an 8-bit data-out register.
//   The selected bank's read data goes back to the CPU over the active-low
//   IV input.
//
// Ports
//   clk         : system clock; all state updates on the rising edge
//   reset       : synchronous, active-high reset
//   IO_SC       : select command; latch the IV value as the bank address
//   IO_WC       : write command; latch the IV value as the bank output data
//   IO_n_LB_w   : write-bank select for SC and WC (0 = left, 1 = right)
//   IO_n_LB_r   : read-bank select (0 = left, 1 = right)
//   n_IV_out    : [7:0] active-low IV bus driven by the CPU
//   n_IV_in     : [7:0] active-low IV bus returned to the CPU
//   LB_Din      : [7:0] read data from the left-bank device
//   RB_Din      : [7:0] read data from the right-bank device
//   LB_Dout     : [7:0] registered write data to the left-bank device
//   RB_Dout     : [7:0] registered write data to the right-bank device
//   IO_address  : [15:0] {left address, right address}
module riptide_io_mod (
  input  logic        clk,
  input  logic        reset,
  input  logic        IO_SC,
  input  logic        IO_WC,
  input  logic        IO_n_LB_w,
  input  logic        IO_n_LB_r,
  input  logic [7:0]  n_IV_out,
  output logic [7:0]  n_IV_in,
  input  logic [7:0]  LB_Din,
  input  logic [7:0]  RB_Din,
  output logic [7:0]  LB_Dout,
  output logic [7:0]  RB_Dout,
  output logic [15:0] IO_address
);

  logic [7:0] wr_data;
  logic [7:0] lb_addr_q, lb_addr_d;
  logic [7:0] rb_addr_q, rb_addr_d;
  logic [7:0] lb_dout_q, lb_dout_d;
  logic [7:0] rb_dout_q, rb_dout_d;

  // The IV bus is active-low, so the true data is simply the inverse.
  assign wr_data = ~n_IV_out;

  always_comb begin
    lb_addr_d = lb_addr_q;
    rb_addr_d = rb_addr_q;
    lb_dout_d = lb_dout_q;
    rb_dout_d = rb_dout_q;
    // SC wins over WC when both are asserted, so data registers hold then.
    if (IO_SC) begin
      if (IO_n_LB_w) rb_addr_d = wr_data;
      else           lb_addr_d = wr_data;
    end else if (IO_WC) begin
      if (IO_n_LB_w) rb_dout_d = wr_data;
      else           lb_dout_d = wr_data;
    end
  end

  // Register stage: commands sampled here appear on the outputs after the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      lb_addr_q <= 8'h00;
      rb_addr_q <= 8'h00;
      lb_dout_q <= 8'h00;
      rb_dout_q <= 8'h00;
    end else begin
      lb_addr_q <= lb_addr_d;
      rb_addr_q <= rb_addr_d;
      lb_dout_q <= lb_dout_d;
      rb_dout_q <= rb_dout_d;
    end
  end

  assign IO_address = {lb_addr_q, rb_addr_q};
  assign LB_Dout    = lb_dout_q;
  assign RB_Dout    = rb_dout_q;

  // Read path is purely combinational and independent of reset/commands.
  assign n_IV_in = ~(IO_n_LB_r ? RB_Din : LB_Din);

endmodule

// File: tb/tb_riptide_io_mod.sv
module tb_riptide_io_mod;

  logic        clk;
  logic        reset;
  logic        IO_SC;
  logic        IO_WC;
  logic        IO_n_LB_w;
  logic        IO_n_LB_r;
  logic [7:0]  n_IV_out;
  logic [7:0]  n_IV_in;
  logic [7:0]  LB_Din;
  logic [7:0]  RB_Din;
  logic [7:0]  LB_Dout;
  logic [7:0]  RB_Dout;
  logic [15:0] IO_address;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [7:0]  lb;
    logic [7:0]  rb;
    logic [7:0]  iv;
  } exp_t;

  exp_t sb_q[$];

  riptide_io_mod dut (
    .clk        (clk),
    .reset      (reset),
    .IO_SC      (IO_SC),
    .IO_WC      (IO_WC),
    .IO_n_LB_w  (IO_n_LB_w),
    .IO_n_LB_r  (IO_n_LB_r),
    .n_IV_out   (n_IV_out),
    .n_IV_in    (n_IV_in),
    .LB_Din     (LB_Din),
    .RB_Din     (RB_Din),
    .LB_Dout    (LB_Dout),
    .RB_Dout    (RB_Dout),
    .IO_address (IO_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the outputs present a new result one edge after each issued
  // vector; sample #1 after the edge and compare against the queue head.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.name, ".IO_address"}, IO_address, e.addr);
      chk({e.name, ".LB_Dout"}, {8'h00, LB_Dout}, {8'h00, e.lb});
      chk({e.name, ".RB_Dout"}, {8'h00, RB_Dout}, {8'h00, e.rb});
      chk({e.name, ".n_IV_in"}, {8'h00, n_IV_in}, {8'h00, e.iv});
    end
  end

  // Drive one vector on the falling edge and queue what the outputs must
  // show after the following rising edge.
  task automatic step(input logic rst, input logic sc, input logic wc,
                      input logic nw, input logic nr, input logic [7:0] niv,
                      input logic [7:0] ldin, input logic [7:0] rdin,
                      input string nm, input logic [15:0] ea,
                      input logic [7:0] el, input logic [7:0] er,
                      input logic [7:0] ei);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    IO_SC     = sc;
    IO_WC     = wc;
    IO_n_LB_w = nw;
    IO_n_LB_r = nr;
    n_IV_out  = niv;
    LB_Din    = ldin;
    RB_Din    = rdin;
    e.name = nm; e.addr = ea; e.lb = el; e.rb = er; e.iv = ei;
    sb_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; IO_SC = 1'b1; IO_WC = 1'b1; IO_n_LB_w = 1'b0; IO_n_LB_r = 1'b0;
    n_IV_out = 8'h00; LB_Din = 8'h12; RB_Din = 8'h34;

    //   rst sc wc nw nr  nIV    LBin   RBin   name          addr      LB     RB     IVin
    step(1, 1, 1, 0, 0, 8'h00, 8'h12, 8'h34, "reset0",     16'h0000, 8'h00, 8'h00, 8'hED);
    step(1, 1, 1, 1, 0, 8'h00, 8'h12, 8'h34, "reset1",     16'h0000, 8'h00, 8'h00, 8'hED);
    step(0, 1, 0, 1, 0, 8'hCA, 8'h12, 8'h34, "sc_rb",      16'h0035, 8'h00, 8'h00, 8'hED);
    step(0, 0, 1, 1, 0, 8'h5A, 8'h12, 8'h34, "wc_rb",      16'h0035, 8'h00, 8'hA5, 8'hED);
    step(0, 1, 0, 0, 0, 8'hFE, 8'h12, 8'h34, "sc_lb",      16'h0135, 8'h00, 8'hA5, 8'hED);
    step(0, 0, 1, 0, 0, 8'h00, 8'h12, 8'h34, "wc_lb",      16'h0135, 8'hFF, 8'hA5, 8'hED);
    step(0, 0, 0, 1, 1, 8'h77, 8'h12, 8'h34, "idle_rd_rb", 16'h0135, 8'hFF, 8'hA5, 8'hCB);
    step(0, 1, 1, 1, 1, 8'h0F, 8'h12, 8'h34, "sc_wc_both", 16'h01F0, 8'hFF, 8'hA5, 8'hCB);
    step(0, 0, 0, 0, 1, 8'h3C, 8'hA0, 8'h5C, "din_change", 16'h01F0, 8'hFF, 8'hA5, 8'hA3);
    step(0, 0, 1, 1, 0, 8'hFF, 8'hA0, 8'h5C, "wc_rb_zero", 16'h01F0, 8'hFF, 8'h00, 8'h5F);
    step(1, 0, 1, 0, 0, 8'h33, 8'hA0, 8'h5C, "reset_mid",  16'h0000, 8'h00, 8'h00, 8'h5F);
    step(0, 0, 0, 0, 1, 8'h33, 8'hA0, 8'h5C, "post_reset", 16'h0000, 8'h00, 8'h00, 8'hA3);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
